cache_arbiter: RTL

Arbitrates a single physical-memory line port between the instruction cache and the data cache. It sits between both caches' pmem-side interfaces and main memory (or the L2). Each transaction is one whole cache line, and exactly one transaction is outstanding at a time. Simultaneous requests are resolved round-robin, and a release cycle after every completion gives the cache controllers time to drop their request lines.

---
 rtl/cache_arb_pkg.sv | 19 +
 rtl/cache_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the I/D cache line-port arbiter.
package cache_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache
// and the D-cache. One transaction outstanding at a time; a one-cycle release
// gap after each completion lets the cache controllers drop their requests.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  requester_t r_last_served;
  requester_t w_next_last;
  logic       r_d_op;        // 1 = write-back, 0 = line read
  logic       w_next_d_op;
  logic       w_i_req;
  logic       w_d_req;

  // Next-state selection, round-robin tie break and per-state output muxing
  always_comb begin
    w_i_req      = i_pmem_read;
    w_d_req      = d_pmem_read | d_pmem_write;
    w_next_state = r_state;
    w_next_last  = r_last_served;
    w_next_d_op  = r_d_op;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_wdata    = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    // Read data is broadcast; only the granted side's resp qualifies it.
    i_pmem_rdata = mem_rdata;
    d_pmem_rdata = mem_rdata;
    unique case (r_state)
      IDLE: begin
        // I wins when it is alone, or on a tie when D was served last.
        if (w_i_req && (!w_d_req || r_last_served == REQ_D)) begin
          w_next_state = GRANT_I;
          w_next_last  = REQ_I;
        end else if (w_d_req) begin
          w_next_state = GRANT_D;
          w_next_last  = REQ_D;
          w_next_d_op  = d_pmem_write;  // write wins if both strobes are up
        end
      end
      GRANT_I: begin
        mem_read    = 1'b1;
        mem_address = i_pmem_address;
        i_pmem_resp = mem_resp;
        if (mem_resp) w_next_state = RELEASE;
      end
      GRANT_D: begin
        mem_read    = ~r_d_op;
        mem_write   = r_d_op;
        mem_address = d_pmem_address;
        mem_wdata   = d_pmem_wdata;
        d_pmem_resp = mem_resp;
        if (mem_resp) w_next_state = RELEASE;
      end
      RELEASE: begin
        // Requests are ignored here so a just-served cache can deassert.
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Arbiter state, fairness record and latched D-side operation
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_last_served <= REQ_I;   // first tie after reset goes to D
      r_d_op        <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_last_served <= w_next_last;
      r_d_op        <= w_next_d_op;
    end
  end

endmodule
